// File: rtl/vc_circular_buffer.sv
// vc_circular_buffer: per-port flit store holding NUM_VC circular queues
// behind one shared write port and one shared read port, with on/off hysteresis.
module vc_circular_buffer #(
    parameter int FLIT_W      = 64,
    parameter int NUM_VC      = 4,
    parameter int BUFFER_SIZE = 8,
    parameter int OFF_THR     = BUFFER_SIZE - 2,
    parameter int ON_THR      = 1,
    localparam int VC_W       = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
    localparam int CNT_W      = $clog2(BUFFER_SIZE + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    write_i,
    input  logic [VC_W-1:0]         write_vc_i,
    input  logic [FLIT_W-1:0]       input_Data,
    input  logic                    read_i,
    input  logic [VC_W-1:0]         read_vc_i,
    output logic [FLIT_W-1:0]       output_Data,
    output logic [NUM_VC-1:0]       buf_empty,
    output logic [NUM_VC-1:0]       buf_full,
    output logic [NUM_VC-1:0]       buf_On_Off,
    output logic [NUM_VC*CNT_W-1:0] occupancy,
    output logic                    overflow_o,
    output logic                    underflow_o
);

    localparam int PTR_W = $clog2(BUFFER_SIZE);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BUFFER_SIZE - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BUFFER_SIZE);
    localparam logic [CNT_W-1:0] CNT_OFF  = CNT_W'(OFF_THR);
    localparam logic [CNT_W-1:0] CNT_ON   = CNT_W'(ON_THR);

    logic [FLIT_W-1:0] mem [NUM_VC][BUFFER_SIZE];
    logic [PTR_W-1:0]  wr_ptr_q [NUM_VC];
    logic [PTR_W-1:0]  rd_ptr_q [NUM_VC];
    logic [CNT_W-1:0]  count_q [NUM_VC];
    logic [CNT_W-1:0]  count_d [NUM_VC];

    logic [NUM_VC-1:0] wr_dec;
    logic [NUM_VC-1:0] rd_dec;
    logic [NUM_VC-1:0] wr_sel;
    logic [NUM_VC-1:0] rd_sel;
    logic [NUM_VC-1:0] wr_ok;
    logic [NUM_VC-1:0] rd_ok;
    logic [NUM_VC-1:0] on_off_q;
    logic              ovf_hit;
    logic              unf_hit;
    logic              overflow_q;
    logic              underflow_q;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // A one-hot shift drops out-of-range VC indices to an all-zero select.
    always_comb begin
        wr_dec    = NUM_VC'(1) << write_vc_i;
        rd_dec    = NUM_VC'(1) << read_vc_i;
        wr_sel    = write_i ? wr_dec : '0;
        rd_sel    = read_i ? rd_dec : '0;
        wr_ok     = '0;
        rd_ok     = '0;
        ovf_hit   = 1'b0;
        unf_hit   = 1'b0;
        buf_empty = '0;
        buf_full  = '0;
        occupancy = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            rd_ok[v] = rd_sel[v] && (count_q[v] != '0);
            // A pop in the same cycle frees the slot a full VC needs.
            wr_ok[v] = wr_sel[v] && ((count_q[v] != CNT_FULL) || rd_ok[v]);
            count_d[v] = count_q[v] + CNT_W'(wr_ok[v]) - CNT_W'(rd_ok[v]);
            if (wr_sel[v] && !wr_ok[v]) ovf_hit = 1'b1;
            if (rd_sel[v] && !rd_ok[v]) unf_hit = 1'b1;
            buf_empty[v] = (count_q[v] == '0);
            buf_full[v]  = (count_q[v] == CNT_FULL);
            occupancy[v*CNT_W +: CNT_W] = count_q[v];
        end
    end

    always_comb begin
        output_Data = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            if (rd_dec[v]) output_Data = mem[v][rd_ptr_q[v]];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int v = 0; v < NUM_VC; v++) begin
                wr_ptr_q[v] <= '0;
                rd_ptr_q[v] <= '0;
                count_q[v]  <= '0;
                on_off_q[v] <= 1'b1;
            end
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                if (wr_ok[v]) wr_ptr_q[v] <= ptr_inc(wr_ptr_q[v]);
                if (rd_ok[v]) rd_ptr_q[v] <= ptr_inc(rd_ptr_q[v]);
                count_q[v] <= count_d[v];
                // Hysteresis: between the thresholds the bit holds.
                if (count_d[v] >= CNT_OFF) begin
                    on_off_q[v] <= 1'b0;
                end else if (count_d[v] <= CNT_ON) begin
                    on_off_q[v] <= 1'b1;
                end
            end
            overflow_q  <= overflow_q | ovf_hit;
            underflow_q <= underflow_q | unf_hit;
        end
    end

    always_ff @(posedge clk) begin
        for (int v = 0; v < NUM_VC; v++) begin
            if (wr_ok[v]) mem[v][wr_ptr_q[v]] <= input_Data;
        end
    end

    assign buf_On_Off  = on_off_q;
    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;

endmodule

// File: tb/tb_vc_circular_buffer.sv
// tb_vc_circular_buffer: scenario tasks plus randomized traffic checked
// against a queue-based reference model of the VC buffer.
module tb_vc_circular_buffer;

    localparam int FW  = 16;
    localparam int NV  = 2;
    localparam int BS  = 4;
    localparam int OFF = 3;
    localparam int ON  = 1;
    localparam int CW  = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          write_i = 1'b0;
    logic [0:0]    write_vc_i = '0;
    logic [FW-1:0] input_Data = '0;
    logic          read_i = 1'b0;
    logic [0:0]    read_vc_i = '0;
    logic [FW-1:0] output_Data;
    logic [NV-1:0] buf_empty;
    logic [NV-1:0] buf_full;
    logic [NV-1:0] buf_On_Off;
    logic [NV*CW-1:0] occupancy;
    logic          overflow_o;
    logic          underflow_o;
    logic [13:0]   dut_status;

    int tests_run = 0;
    int tests_failed = 0;

    logic [FW-1:0] mq [NV][$];
    logic [NV-1:0] m_on;
    bit            m_ovf;
    bit            m_unf;

    always #5 clk = ~clk;

    vc_circular_buffer #(
        .FLIT_W(FW), .NUM_VC(NV), .BUFFER_SIZE(BS),
        .OFF_THR(OFF), .ON_THR(ON)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .write_i(write_i), .write_vc_i(write_vc_i),
        .input_Data(input_Data),
        .read_i(read_i), .read_vc_i(read_vc_i),
        .output_Data(output_Data),
        .buf_empty(buf_empty), .buf_full(buf_full),
        .buf_On_Off(buf_On_Off), .occupancy(occupancy),
        .overflow_o(overflow_o), .underflow_o(underflow_o)
    );

    assign dut_status = {buf_empty, buf_full, buf_On_Off,
                         occupancy, overflow_o, underflow_o};

    function automatic void model_reset();
        for (int v = 0; v < NV; v++) mq[v].delete();
        m_on  = '1;
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endfunction

    function automatic void model_step();
        bit rok;
        bit wok;
        rok = 1'b0;
        wok = 1'b0;
        if (read_i) begin
            if (mq[read_vc_i].size() > 0) rok = 1'b1;
            else m_unf = 1'b1;
        end
        if (write_i) begin
            wok = (mq[write_vc_i].size() < BS) ||
                  (rok && (read_vc_i == write_vc_i));
            if (!wok) m_ovf = 1'b1;
        end
        if (rok) void'(mq[read_vc_i].pop_front());
        if (wok) mq[write_vc_i].push_back(input_Data);
        for (int v = 0; v < NV; v++) begin
            if (mq[v].size() >= OFF) m_on[v] = 1'b0;
            else if (mq[v].size() <= ON) m_on[v] = 1'b1;
        end
    endfunction

    function automatic logic [13:0] exp_status();
        logic [NV-1:0] e;
        logic [NV-1:0] f;
        logic [NV*CW-1:0] o;
        for (int v = 0; v < NV; v++) begin
            e[v] = (mq[v].size() == 0);
            f[v] = (mq[v].size() == BS);
            o[v*CW +: CW] = CW'(mq[v].size());
        end
        return {e, f, m_on, o, m_ovf, m_unf};
    endfunction

    task automatic set_in(input bit w, input bit wv, input logic [FW-1:0] d,
                          input bit r, input bit rv);
        @(negedge clk);
        write_i    = w;
        write_vc_i = wv;
        input_Data = d;
        read_i     = r;
        read_vc_i  = rv;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        write_i = 1'b0;
        read_i  = 1'b0;
        rst_n   = 1'b0;
        model_reset();
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (dut_status !== exp_status()) begin
            tests_failed++;
            $display("FAIL reset_state got %h want %h", dut_status, exp_status());
        end
        tests_run++;
        if (dut_status !== 14'b11_00_11_000000_0_0) begin
            tests_failed++;
            $display("FAIL reset_const got %b want 11001100000000", dut_status);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_fill_vc0();
        for (int i = 0; i < 5; i++) begin
            set_in(1'b1, 1'b0, 16'hA000 + FW'(i), 1'b0, 1'b0);
            tick();
            tests_run++;
            if (dut_status !== exp_status()) begin
                tests_failed++;
                $display("FAIL fill%0d got %h want %h", i, dut_status, exp_status());
            end
            if (i == 2) begin
                tests_run++;
                if (buf_On_Off[0] !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL fill_onoff got %b want 0", buf_On_Off[0]);
                end
            end
            if (i == 3) begin
                tests_run++;
                if (buf_full[0] !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL fill_full got %b want 1", buf_full[0]);
                end
            end
            if (i == 4) begin
                tests_run++;
                if (overflow_o !== 1'b1 || occupancy !== 6'b000_100) begin
                    tests_failed++;
                    $display("FAIL fill_ovf got ovf=%b occ=%b want ovf=1 occ=000100",
                             overflow_o, occupancy);
                end
            end
        end
    endtask

    task automatic test_drain_vc0();
        for (int i = 0; i < 5; i++) begin
            set_in(1'b0, 1'b0, '0, 1'b1, 1'b0);
            if (i < 4) begin
                tests_run++;
                if (output_Data !== 16'hA000 + FW'(i)) begin
                    tests_failed++;
                    $display("FAIL drain_data%0d got %h want %h",
                             i, output_Data, 16'hA000 + FW'(i));
                end
            end
            tick();
            tests_run++;
            if (dut_status !== exp_status()) begin
                tests_failed++;
                $display("FAIL drain%0d got %h want %h", i, dut_status, exp_status());
            end
            if (i == 2) begin
                tests_run++;
                if (buf_On_Off[0] !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL drain_onoff got %b want 1", buf_On_Off[0]);
                end
            end
            if (i == 4) begin
                tests_run++;
                if (underflow_o !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL drain_unf got %b want 1", underflow_o);
                end
            end
        end
    endtask

    task automatic test_wrap_vc1();
        int pushes = 0;
        int pops = 0;
        for (int it = 0; it < 20 && pops < 6; it++) begin
            bit can_w;
            bit can_r;
            bit do_w;
            can_w = (pushes < 6) && (mq[1].size() < 3);
            can_r = (mq[1].size() > 0);
            do_w = can_w && (!can_r || ($urandom_range(0, 1) == 1));
            if (do_w) begin
                set_in(1'b1, 1'b1, FW'($urandom), 1'b0, 1'b1);
                pushes++;
            end else begin
                set_in(1'b0, 1'b1, '0, 1'b1, 1'b1);
                tests_run++;
                if (output_Data !== mq[1][0]) begin
                    tests_failed++;
                    $display("FAIL wrap_data%0d got %h want %h", pops, output_Data, mq[1][0]);
                end
                pops++;
            end
            tick();
            tests_run++;
            if (dut_status !== exp_status()) begin
                tests_failed++;
                $display("FAIL wrap_status got %h want %h", dut_status, exp_status());
            end
        end
        tests_run++;
        if (pops != 6 || occupancy[5:3] !== 3'd0) begin
            tests_failed++;
            $display("FAIL wrap_end got pops=%0d occ1=%0d want 6 and 0", pops, occupancy[5:3]);
        end
    endtask

    task automatic test_simul_full();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 1'b0, FW'($urandom), 1'b0, 1'b0);
            tick();
        end
        set_in(1'b1, 1'b0, 16'hB000, 1'b1, 1'b0);
        tests_run++;
        if (output_Data !== mq[0][0]) begin
            tests_failed++;
            $display("FAIL sfull_head got %h want %h", output_Data, mq[0][0]);
        end
        tick();
        tests_run++;
        if (dut_status !== exp_status() || overflow_o !== 1'b0 ||
            occupancy[2:0] !== 3'd4) begin
            tests_failed++;
            $display("FAIL sfull_status got %h want %h", dut_status, exp_status());
        end
        for (int i = 0; i < 4; i++) begin
            logic [FW-1:0] want;
            want = (i == 3) ? 16'hB000 : mq[0][0];
            set_in(1'b0, 1'b0, '0, 1'b1, 1'b0);
            tests_run++;
            if (output_Data !== want) begin
                tests_failed++;
                $display("FAIL sfull_drain%0d got %h want %h", i, output_Data, want);
            end
            tick();
        end
    endtask

    task automatic test_simul_empty();
        do_reset();
        set_in(1'b1, 1'b1, 16'hC000, 1'b1, 1'b1);
        tick();
        tests_run++;
        if (dut_status !== exp_status() || underflow_o !== 1'b1 ||
            occupancy[5:3] !== 3'd1) begin
            tests_failed++;
            $display("FAIL sempty_status got %h want %h", dut_status, exp_status());
        end
        set_in(1'b0, 1'b0, '0, 1'b0, 1'b1);
        tests_run++;
        if (output_Data !== 16'hC000) begin
            tests_failed++;
            $display("FAIL sempty_data got %h want c000", output_Data);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            set_in(1'b1, 1'b0, FW'($urandom), 1'b0, 1'b0);
            tick();
        end
        set_in(1'b0, 1'b0, '0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        tests_run++;
        if (dut_status !== 14'b11_00_11_000000_0_0) begin
            tests_failed++;
            $display("FAIL areset_now got %b want 11001100000000", dut_status);
        end
        @(negedge clk);
        rst_n = 1'b1;
        set_in(1'b1, 1'b0, 16'hD000, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 1'b0, '0, 1'b1, 1'b0);
        tests_run++;
        if (output_Data !== 16'hD000) begin
            tests_failed++;
            $display("FAIL areset_data got %h want d000", output_Data);
        end
        tick();
        tests_run++;
        if (dut_status !== exp_status()) begin
            tests_failed++;
            $display("FAIL areset_status got %h want %h", dut_status, exp_status());
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 300; i++) begin
            bit rv;
            rv = 1'($urandom);
            set_in(1'($urandom), 1'($urandom), FW'($urandom), 1'($urandom), rv);
            if (mq[rv].size() > 0) begin
                tests_run++;
                if (output_Data !== mq[rv][0]) begin
                    tests_failed++;
                    $display("FAIL rand_data%0d got %h want %h", i, output_Data, mq[rv][0]);
                end
            end
            tick();
            tests_run++;
            if (dut_status !== exp_status()) begin
                tests_failed++;
                $display("FAIL rand_status%0d got %h want %h", i, dut_status, exp_status());
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill_vc0();
        test_drain_vc0();
        test_wrap_vc1();
        test_simul_full();
        test_simul_empty();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout after %0d tests", tests_run);
        $fatal(1);
    end

endmodule

// File: doc/vc_circular_buffer.md
Name: vc_circular_buffer

Overview:
- Per-input-port flit store for the NoC router; next generation of the single-queue circular buffer.
- Holds NUM_VC independent circular queues of BUFFER_SIZE flits each, behind one shared write port and one shared read port, each addressed by VC index.
- Per-VC on/off flow control uses hysteresis thresholds.
- Per-VC occupancy and sticky error flags go to the switch allocator and debug logic.

Parameters:
- FLIT_W, 64: flit width in bits; equals the packed width of the codebase flit struct.
- NUM_VC, 4: number of virtual channels; minimum 1.
- BUFFER_SIZE, 8: depth per VC in flits; minimum 2, need not be a power of two.
- OFF_THR, BUFFER_SIZE-2: occupancy at or above which the VC's on/off bit drops to 0.
- ON_THR, 1: occupancy at or below which the bit returns to 1. Must be less than OFF_THR.
- Derived VC_W = max(1, clog2(NUM_VC)).
- Derived CNT_W = clog2(BUFFER_SIZE+1).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- write_i  in  1  write request.
- write_vc_i  in  VC_W  target VC of the write.
- input_Data  in  FLIT_W  flit to write.
- read_i  in  1  read (pop) request.
- read_vc_i  in  VC_W  VC to read and pop.
- output_Data  out  FLIT_W  head flit of read_vc_i.
- buf_empty  out  NUM_VC  per-VC empty.
- buf_full  out  NUM_VC  per-VC full.
- buf_On_Off  out  NUM_VC  per-VC flow control; 1 means upstream may send.
- occupancy  out  NUM_VC*CNT_W  per-VC flit count; VC v is at bits [v*CNT_W +: CNT_W].
- overflow_o  out  1  sticky: write to a full VC was attempted.
- underflow_o  out  1  sticky: read from an empty VC was attempted.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All read/write pointers and counts go to 0.
  - buf_empty all 1; buf_full all 0; buf_On_Off all 1; occupancy 0.
  - overflow_o and underflow_o 0.
  - Memory contents are not reset.
  - Reset mid-operation discards all stored flits. The first write after deassertion lands at slot 0.
- Storage: memory[v][p], with per-VC wr_ptr, rd_ptr and count, all registered.
- Pointer wrap: a pointer advances by 1 and goes from BUFFER_SIZE-1 to 0. No modulo power-of-two trick is used.
- Write: on a clk edge with write_i=1 and write_vc_i<NUM_VC and the VC not full:
  - memory[vc][wr_ptr] <= input_Data; wr_ptr advances; count increments.
- Read: first-word fall-through.
  - output_Data = memory[read_vc_i][rd_ptr[read_vc_i]], combinational from read_vc_i.
  - It is valid only when buf_empty[read_vc_i]=0; otherwise the value is don't-care.
  - On a clk edge with read_i=1, a legal VC and the VC not empty: rd_ptr advances and count decrements.
- Out-of-range VC index (>= NUM_VC): the request is ignored. No flag is set and no state changes.
- Full VC plus write:
  - The write is dropped and overflow_o sets.
  - Exception: if a legal read of the same VC occurs in the same cycle, the write is accepted. Count stays at BUFFER_SIZE and no flag is set.
- Empty VC plus read:
  - The read is ignored and underflow_o sets.
  - A write to the same VC in the same cycle is still accepted, with no bypass: the new flit becomes visible on output_Data the next cycle and count becomes 1.
  - underflow_o still sets in this case.
- Same VC, legal read and write in one cycle: both occur and count is unchanged.
- Different VCs in one cycle: the two operations are fully independent.
- Sticky flags: overflow_o and underflow_o clear only on reset.
- buf_empty[v] = (count==0) and buf_full[v] = (count==BUFFER_SIZE). Both are combinational from the registered counts, so they are valid in the cycle after an update.
- buf_On_Off[v] is a register evaluated on next_count:
  - Clears when next_count >= OFF_THR.
  - Sets when next_count <= ON_THR.
  - Otherwise holds (hysteresis).
  - It changes in the same edge as the count update, so there is 0 cycles of lag.
- Latency: write to output_Data visibility is 1 cycle. Read pop to next head is 1 cycle.

Test Plan:
- Configuration for all scenarios: NUM_VC=2, BUFFER_SIZE=4, OFF_THR=3, ON_THR=1, FLIT_W=16.
- Reset then idle -> buf_empty=2'b11, buf_full=0, buf_On_Off=2'b11, occupancy=0, both flags 0.
- Write 0xA000, 0xA001, 0xA002, 0xA003 to VC0 -> buf_On_Off[0]=0 after the 3rd write, buf_full[0]=1 after the 4th. A 5th write of 0xA004 sets overflow_o, occupancy VC0 stays 4, and VC1 is untouched.
- Pop VC0 four times -> output_Data reads 0xA000, 0xA001, 0xA002, 0xA003 in order. buf_On_Off[0] returns to 1 after the 3rd pop (count 1). A 5th pop sets underflow_o.
- Wrap: write 6 flits and pop 6 on VC1, interleaved with count at most 3 -> FIFO order is preserved across the pointer wrap and count ends at 0.
- Simultaneous ops:
  - VC0 full plus read and write of 0xB000 in the same cycle -> count stays 4, no overflow, and 0xB000 emerges after the 3 older flits.
  - VC1 empty plus read and write of 0xC000 in the same cycle -> count becomes 1, underflow_o sets, and output_Data=0xC000 next cycle with read_vc_i=1.
- Asynchronous reset asserted mid-stream with VC0 holding 2 flits, applied between clock edges -> all outputs return to reset values immediately. A subsequent write then read of 0xD000 returns 0xD000.
